// File: rtl/spi_master.sv
// Byte-wide mode-0 SPI master: one full-duplex 8-bit frame per start strobe,
// framed by ce0 with a guaranteed ce0-high gap before the done pulse.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       sclk,
    output logic       mosi,
    output logic       ce0,
    input  logic       miso
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic          sclk_q;
    logic          done_q;
    logic [7:0]    rx_q;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic          load, rise, fall, finish, reload;
    logic          phase_end;
    logic          frame_on;

    assign phase_end = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        rise    = 1'b0;
        fall    = 1'b0;
        finish  = 1'b0;
        reload  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    load    = 1'b1;
                    reload  = 1'b1;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = SHIFT;
                    rise    = 1'b1;
                    reload  = 1'b1;
                end
            end
            SHIFT: begin
                // Each phase end either drops sclk, or after the last low
                // half-period moves to HOLD instead of raising it again.
                if (phase_end) begin
                    reload = 1'b1;
                    if (sclk_q)             fall    = 1'b1;
                    else if (bit_q == 3'd7) state_d = HOLD;
                    else                    rise    = 1'b1;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = GAP;
                    reload  = 1'b1;
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            bit_q  <= 3'd0;
            sclk_q <= 1'b0;
            done_q <= 1'b0;
            rx_q   <= 8'h00;
        end else begin
            if (reload)             cnt_q <= RELOAD;
            else if (!phase_end)    cnt_q <= cnt_q - CW'(1);
            if (load)               bit_q <= 3'd0;
            else if (rise && state_q == SHIFT) bit_q <= bit_q + 3'd1;
            if (rise)               sclk_q <= 1'b1;
            else if (fall)          sclk_q <= 1'b0;
            done_q <= finish;
            if (finish)             rx_q <= rx_sr;
        end
    end

    // tx keeps tx[0] in its MSB after the last falling edge so mosi holds it.
    always_ff @(posedge clk) begin
        if (load)                        tx_sr <= tx_data;
        else if (fall && bit_q != 3'd7)  tx_sr <= {tx_sr[6:0], 1'b0};
        if (rise)                        rx_sr <= {rx_sr[6:0], miso};
    end

    assign frame_on = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign ce0      = ~frame_on;
    assign mosi     = frame_on & tx_sr[7];
    assign sclk     = sclk_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rx_data  = rx_q;
endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master at CLK_DIV=4 and CLK_DIV=2; every pin is
// compared each cycle against a waveform computed from the frame timing rules.
module tb_spi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_w[2], start_w[2], miso_w[2];
    logic [7:0] tx_w[2], rx_w[2];
    logic       busy_w[2], done_w[2], sclk_w[2], mosi_w[2], ce0_w[2];
    logic       loop_m[2];
    logic       slv_miso[2];
    logic [7:0] slv_ret[2], slv_cap[2], slv_latched[2];
    logic [7:0] rx_exp[2];
    int         n_chk = 0;
    int         n_fail = 0;

    spi_master #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst_w[0]), .start(start_w[0]), .tx_data(tx_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .rx_data(rx_w[0]), .sclk(sclk_w[0]),
        .mosi(mosi_w[0]), .ce0(ce0_w[0]), .miso(miso_w[0])
    );

    spi_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst_w[1]), .start(start_w[1]), .tx_data(tx_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .rx_data(rx_w[1]), .sclk(sclk_w[1]),
        .mosi(mosi_w[1]), .ce0(ce0_w[1]), .miso(miso_w[1])
    );

    // Mode-0 slave: first bit ready at ce0 fall, next bit just after each sclk rise.
    for (genvar g = 0; g < 2; g++) begin : g_slave
        int bi = -1;
        assign miso_w[g] = loop_m[g] ? mosi_w[g] : slv_miso[g];
        always @(negedge ce0_w[g] or posedge sclk_w[g]) begin
            if (sclk_w[g] === 1'b1) begin
                slv_cap[g] = {slv_cap[g][6:0], mosi_w[g]};
                #1;
                if (bi >= 0) begin
                    slv_miso[g] = slv_ret[g][bi];
                    bi--;
                end
            end else if (ce0_w[g] === 1'b0) begin
                bi = 6;
                slv_miso[g] = slv_ret[g][7];
                slv_cap[g] = 8'h00;
            end
        end
        always @(posedge ce0_w[g]) slv_latched[g] = slv_cap[g];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [4:0] pins(input int i);
        return {busy_w[i], done_w[i], ce0_w[i], sclk_w[i], mosi_w[i]};
    endfunction

    // Expected {busy, done, ce0, sclk, mosi} at cycle t after acceptance.
    function automatic logic [4:0] model_pins(input int d, input int t, input logic [7:0] tx);
        logic b, dn, c, s, m;
        int   k;
        b  = (t >= 1) && (t <= 19 * d);
        dn = (t == 19 * d + 1);
        c  = !((t >= 1) && (t <= 18 * d));
        s  = (t >= d + 1) && (t <= 16 * d) && ((((t - 1) / d) % 2) == 1);
        k  = (t - 1) / (2 * d);
        if (k > 7) k = 7;
        m  = ((t >= 1) && (t <= 18 * d)) ? tx[7 - k] : 1'b0;
        return {b, dn, c, s, m};
    endfunction

    task automatic idle(input int i, input int n);
        start_w[i] = 1'b0;
        for (int u = 0; u < n; u++) begin
            tick();
            chk("idle_pins", 32'(pins(i)), 32'(5'b00100));
            chk("idle_rx", 32'(rx_w[i]), 32'(rx_exp[i]));
        end
    endtask

    // Called at a negedge; this cycle is cycle 0. Returns at the done cycle.
    task automatic run_frame(input int i, input logic [7:0] tx, input logic lp,
                             input logic [7:0] ret, input logic extra, input int rst_at);
        int         d = (i == 0) ? 4 : 2;
        int         last = 19 * d + 1;
        int         rises = 0;
        int         lows = 0;
        logic       sclk_prev = 1'b0;
        logic [7:0] want_rx = lp ? tx : ret;
        loop_m[i]  = lp;
        slv_ret[i] = ret;
        start_w[i] = 1'b1;
        tx_w[i]    = tx;
        for (int t = 1; t <= last; t++) begin
            tick();
            start_w[i] = extra && (t == 10 || t == 40);
            tx_w[i]    = 8'($urandom);
            chk($sformatf("pins_d%0d_t%0d", d, t), 32'(pins(i)), 32'(model_pins(d, t, tx)));
            if (sclk_w[i] && !sclk_prev) rises++;
            sclk_prev = sclk_w[i];
            if (!ce0_w[i]) lows++;
            if (t < last) chk("rx_hold", 32'(rx_w[i]), 32'(rx_exp[i]));
            if (t == rst_at) begin
                start_w[i] = 1'b0;
                rst_w[i] = 1'b1;
                tick();
                rst_w[i] = 1'b0;
                chk("rst_pins", 32'(pins(i)), 32'(5'b00100));
                chk("rst_rx", 32'(rx_w[i]), 32'(8'h00));
                rx_exp[i] = 8'h00;
                idle(i, 20 * d);
                return;
            end
        end
        chk("rx_done", 32'(rx_w[i]), 32'(want_rx));
        chk("slave_cap", 32'(slv_latched[i]), 32'(tx));
        chk("sclk_rises", 32'(rises), 32'(8));
        chk("ce0_low", 32'(lows), 32'(18 * d));
        rx_exp[i] = want_rx;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_w[i] = 1'b1; start_w[i] = 1'b0; tx_w[i] = 8'h00;
            loop_m[i] = 1'b1; slv_ret[i] = 8'h00; rx_exp[i] = 8'h00;
            slv_miso[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("reset_pins", 32'(pins(i)), 32'(5'b00100));
            chk("reset_rx", 32'(rx_w[i]), 32'(8'h00));
            rst_w[i] = 1'b0;
        end
        tick();

        run_frame(0, 8'hA5, 1'b1, 8'h00, 1'b0, 0);
        idle(0, 5);
        run_frame(0, 8'hC3, 1'b0, 8'h3C, 1'b0, 0);
        idle(0, 5);
        run_frame(0, 8'($urandom), 1'b1, 8'h00, 1'b1, 0);
        idle(0, 30);
        run_frame(0, 8'h01, 1'b1, 8'h00, 1'b0, 0);
        run_frame(0, 8'h80, 1'b1, 8'h00, 1'b0, 0);
        idle(0, 3);
        run_frame(0, 8'h5A, 1'b0, 8'($urandom), 1'b0, 30);
        run_frame(0, 8'($urandom), 1'b0, 8'($urandom), 1'b0, 0);
        idle(0, 3);
        run_frame(1, 8'hFF, 1'b1, 8'h00, 1'b0, 0);
        idle(1, 4);
        run_frame(1, 8'h00, 1'b1, 8'h00, 1'b0, 0);
        idle(1, 4);

        for (int n = 0; n < 24; n++) begin
            int i;
            int rat;
            i   = int'($urandom_range(0, 1));
            rat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, (i == 0) ? 76 : 38)) : 0;
            run_frame(i, 8'($urandom), 1'($urandom), 8'($urandom),
                      (i == 0) ? 1'($urandom) : 1'b0, rat);
            if ($urandom_range(0, 1) == 0) idle(i, int'($urandom_range(1, 4)));
            else if (rat != 0) idle(i, 1);
            else idle(i, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
